// File: rtl/game_pkg.sv
// Shared game status encoding for the sequencer and the blocks that display or react to it.
// Latency: n/a (types only).
// Backpressure: n/a.
package game_pkg;

  typedef enum logic [2:0] {
    STATUS_PLAYING   = 3'd0,
    STATUS_LEVEL_WIN = 3'd1,
    STATUS_WORLD_WIN = 3'd2,
    STATUS_GAME_WIN  = 3'd3,
    STATUS_GAME_OVER = 3'd4,
    STATUS_IDLE      = 3'd5,
    STATUS_PAUSED    = 3'd6
  } status_t;

endpackage

// File: rtl/game_timer.sv
// Loadable down-counter for banner and immunity windows; counts only while run is high.
// Latency: load takes effect after the edge; done is high in the last counted cycle.
// Backpressure: none; run freezes the count, load restarts it.
// Ports: clk, rst (async active-low), load (restart at CYCLES), run (count enable),
//        busy (count non-zero), done (one-cycle pulse in the final run cycle).
module game_timer #(
  parameter  int CYCLES = 4,
  localparam int CW     = $clog2(CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic busy,
  output logic done
);

  logic [CW-1:0] count;

  assign busy = (count != '0);
  // Raised during the last counted cycle so the owner can act on the same edge
  // that retires the window; a reload supersedes a stale expiry.
  assign done = run && !load && (count == CW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(CYCLES);
    end else if (run && busy) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game progress sequencer: world/level/lives/scroll tracking, win banners, hit immunity, pause.
// Latency: every input sampled at edge N is reflected on the registered outputs after edge N.
// Backpressure: none; pulses arriving in states that do not use them are dropped.
// Ports: clk, rst (async active-low), start, pause (raw button), scroll_got, hit (pulses);
//        level, world, lives, scrolls_left, game_status, level_load (strobe), invulnerable.
module game_sequencer
  import game_pkg::*;
#(
  parameter  int NUM_LEVELS        = 6,
  parameter  int NUM_WORLDS        = 2,
  parameter  int NUM_LIVES         = 3,
  parameter  int SCROLLS_PER_LEVEL = 6,
  parameter  int BANNER_CYCLES     = 100_000_000,
  parameter  int INVULN_CYCLES     = 50_000_000,
  localparam int LW                = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int WW                = (NUM_WORLDS > 1) ? $clog2(NUM_WORLDS) : 1,
  localparam int LFW               = $clog2(NUM_LIVES + 1),
  localparam int SW                = $clog2(SCROLLS_PER_LEVEL + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           pause,
  input  logic           scroll_got,
  input  logic           hit,
  output logic [LW-1:0]  level,
  output logic [WW-1:0]  world,
  output logic [LFW-1:0] lives,
  output logic [SW-1:0]  scrolls_left,
  output logic [2:0]     game_status,
  output logic           level_load,
  output logic           invulnerable
);

  localparam logic [LW-1:0]  LAST_LEVEL   = LW'(NUM_LEVELS - 1);
  localparam logic [WW-1:0]  LAST_WORLD   = WW'(NUM_WORLDS - 1);
  localparam logic [LFW-1:0] FULL_LIVES   = LFW'(NUM_LIVES);
  localparam logic [SW-1:0]  FULL_SCROLLS = SW'(SCROLLS_PER_LEVEL);

  status_t state;
  logic    pause_q;
  logic    pause_edge;
  logic    playing;
  logic    in_banner;
  logic    level_clear;
  logic    take_hit;
  logic    banner_done;
  logic    invuln_done;
  logic    banner_busy;
  logic    invuln_busy;
  logic    unused_busy;

  assign game_status = state;
  assign playing     = (state == STATUS_PLAYING);
  assign in_banner   = (state == STATUS_LEVEL_WIN) || (state == STATUS_WORLD_WIN);
  assign pause_edge  = pause && !pause_q;

  // Priority inside PLAYING: a pause edge swallows same-cycle pulses, and the
  // final scroll of a level swallows a same-cycle hit.
  assign level_clear = playing && !pause_edge && scroll_got && (scrolls_left == SW'(1));
  assign take_hit    = playing && !pause_edge && hit && !invulnerable && !level_clear;

  // Completion is signalled through done; the busy flags are not needed here.
  assign unused_busy = banner_busy ^ invuln_busy;

  game_timer #(.CYCLES(BANNER_CYCLES)) u_banner_timer (
    .clk  (clk),
    .rst  (rst),
    .load (level_clear),
    .run  (in_banner),
    .busy (banner_busy),
    .done (banner_done)
  );

  // Only PLAYING cycles advance the immunity window, so PAUSED freezes it.
  game_timer #(.CYCLES(INVULN_CYCLES)) u_invuln_timer (
    .clk  (clk),
    .rst  (rst),
    .load (take_hit && (lives > LFW'(1))),
    .run  (playing),
    .busy (invuln_busy),
    .done (invuln_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= STATUS_IDLE;
      level        <= '0;
      world        <= '0;
      lives        <= FULL_LIVES;
      scrolls_left <= FULL_SCROLLS;
      level_load   <= 1'b0;
      invulnerable <= 1'b0;
      pause_q      <= 1'b0;
    end else begin
      pause_q    <= pause;
      level_load <= 1'b0;
      case (state)
        STATUS_IDLE, STATUS_GAME_WIN, STATUS_GAME_OVER: begin
          if (start) begin
            level        <= '0;
            world        <= '0;
            lives        <= FULL_LIVES;
            scrolls_left <= FULL_SCROLLS;
            invulnerable <= 1'b0;
            level_load   <= 1'b1;
            state        <= STATUS_PLAYING;
          end
        end
        STATUS_PLAYING: begin
          if (invuln_done) invulnerable <= 1'b0;
          if (pause_edge) begin
            state <= STATUS_PAUSED;
          end else if (level_clear) begin
            scrolls_left <= '0;
            invulnerable <= 1'b0;
            if (level != LAST_LEVEL)      state <= STATUS_LEVEL_WIN;
            else if (world != LAST_WORLD) state <= STATUS_WORLD_WIN;
            else                          state <= STATUS_GAME_WIN;
          end else begin
            if (scroll_got) scrolls_left <= scrolls_left - SW'(1);
            if (take_hit) begin
              if (lives > LFW'(1)) begin
                lives        <= lives - LFW'(1);
                invulnerable <= 1'b1;
              end else begin
                lives <= '0;
                state <= STATUS_GAME_OVER;
              end
            end
          end
        end
        STATUS_PAUSED: begin
          if (pause_edge) state <= STATUS_PLAYING;
        end
        STATUS_LEVEL_WIN, STATUS_WORLD_WIN: begin
          if (banner_done) begin
            scrolls_left <= FULL_SCROLLS;
            level_load   <= 1'b1;
            state        <= STATUS_PLAYING;
            if (state == STATUS_LEVEL_WIN) begin
              level <= level + LW'(1);
            end else begin
              level <= '0;
              world <= world + WW'(1);
            end
          end
        end
        default: state <= STATUS_IDLE;
      endcase
    end
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Parametrised successor to the fixed-size game FSM in the top-level `Game` module. It tracks world, level, lives and remaining scrolls, and runs timed win banners, an invulnerability window after each hit, and a pause mode. It sits between the collision logic (scroll pickups and wall hits) and the `Scrolls`/`Obstacles`/`VideoController` blocks. Those blocks take `level`, `world`, `game_status` and the `level_load` reinit strobe from it.

## Interface
Parameters:
- `NUM_LEVELS`, default 6: levels per world, ≥1.
- `NUM_WORLDS`, default 2: worlds per game, ≥1.
- `NUM_LIVES`, default 3: lives at game start, ≥1.
- `SCROLLS_PER_LEVEL`, default 6: pickups needed to clear a level, ≥1.
- `BANNER_CYCLES`, default 100_000_000: cycles a LEVEL_WIN/WORLD_WIN banner is held.
- `INVULN_CYCLES`, default 50_000_000: hit-immunity window.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  level-sensitive; acted on only in IDLE, GAME_WIN or GAME_OVER.
- `pause`  in  1  raw button level; edge-detected internally.
- `scroll_got`  in  1  one-cycle pulse: player collected a scroll.
- `hit`  in  1  one-cycle pulse: player touched a wall.
- `level`  out  $clog2(NUM_LEVELS) (min 1)  current level, 0-based.
- `world`  out  $clog2(NUM_WORLDS) (min 1)  current world, 0-based.
- `lives`  out  $clog2(NUM_LIVES+1)  lives remaining.
- `scrolls_left`  out  $clog2(SCROLLS_PER_LEVEL+1)  scrolls still needed.
- `game_status`  out  3  encoding:
  - 0 PLAYING
  - 1 LEVEL_WIN
  - 2 WORLD_WIN
  - 3 GAME_WIN
  - 4 GAME_OVER
  - 5 IDLE
  - 6 PAUSED
- `level_load`  out  1  one-cycle strobe: reinitialise level content.
- `invulnerable`  out  1  high while the immunity window runs.

## Operation
- Reset values:
  - `game_status`=IDLE; `level`=0, `world`=0.
  - `lives`=NUM_LIVES, `scrolls_left`=SCROLLS_PER_LEVEL.
  - `level_load`=0, `invulnerable`=0; both timers cleared.
- IDLE, GAME_WIN, GAME_OVER, with `start`=1:
  - `level`=0, `world`=0, `lives`=NUM_LIVES, `scrolls_left`=SCROLLS_PER_LEVEL.
  - `invulnerable`=0; pulse `level_load`; go to PLAYING.
- PLAYING:
  - Pause rising edge: go to PAUSED.
  - `scroll_got` with `scrolls_left`>1: decrement `scrolls_left`.
  - `scroll_got` with `scrolls_left`==1, so the level is cleared:
    - `scrolls_left`:=0 in all three cases below.
    - `level`<NUM_LEVELS-1: go to LEVEL_WIN.
    - Last level, `world`<NUM_WORLDS-1: go to WORLD_WIN.
    - Last level of last world: go to GAME_WIN.
  - `hit` with `invulnerable`=0 and `lives`>1: decrement `lives`; start the INVULN timer.
  - `hit` with `invulnerable`=0 and `lives`==1: `lives`:=0; go to GAME_OVER.
  - `hit` with `invulnerable`=1: ignored.
  - Final `scroll_got` and `hit` in the same cycle: the scroll wins, the level is cleared and the hit is discarded.
  - Pause edge and `scroll_got`/`hit` in the same cycle: pause wins and the pulses are discarded.
- PAUSED:
  - `scroll_got` and `hit` are ignored.
  - The INVULN timer is frozen; `invulnerable` holds its value.
  - Pause rising edge: return to PLAYING.
- LEVEL_WIN and WORLD_WIN:
  - The banner timer runs. On expiry, `scrolls_left`:=SCROLLS_PER_LEVEL, `level_load` pulses, and the FSM returns to PLAYING.
  - LEVEL_WIN on expiry: `level`+1.
  - WORLD_WIN on expiry: `level`:=0, `world`+1.
  - `lives` carries over. `invulnerable` is cleared on entry to either banner.
- GAME_WIN and GAME_OVER hold until `start`; `pause` is ignored.

## Timing
- All outputs are registered.
- An input sampled at edge N takes effect on the outputs after edge N.
- Pause edge detect uses one register, so the status change follows the first cycle `pause` is seen high.
- The banner is visible for exactly BANNER_CYCLES cycles. In the first PLAYING cycle after it, `level_load`=1 and the new `level` is already valid.
- `invulnerable` is high for exactly INVULN_CYCLES PLAYING cycles starting the cycle after the hit; PAUSED cycles do not count.
- A reset assertion mid-banner or mid-invulnerability forces reset values immediately, asynchronously.
- Counters never wrap; the FSM guarantees the bounds.

## Structure
- Shared package `game_pkg`: the `game_status` encoding constants (STATUS_PLAYING … STATUS_PAUSED). VideoController and Scrolls/Obstacles import it as well.
- Sub-module `game_timer` (parameter `CYCLES`):
  - Ports: `clk`, `rst`, `load`, `run`; outputs `busy`, `done`.
  - `done` is a one-cycle pulse.
  - Two instances: banner and invulnerability.

## Test plan
All scenarios use NUM_LEVELS=2, NUM_WORLDS=2, NUM_LIVES=2, SCROLLS_PER_LEVEL=3, BANNER_CYCLES=4, INVULN_CYCLES=3.
1. Reset, then `start` → `game_status`=5 then 0; `level_load` high for 1 cycle; `lives`=2, `scrolls_left`=3.
2. Three `scroll_got` pulses at level 0 → `scrolls_left` goes 2,1,0 and status=1 for 4 cycles; then `level`=1, `scrolls_left`=3, status=0 with `level_load`.
3. Clear level 1 of world 0 → status=2 for 4 cycles, then `world`=1, `level`=0. Clear both levels of world 1 → status=3, held until `start`.
4. Three `hit` pulses on consecutive cycles → `lives`=1 and `invulnerable` high 3 cycles; 2nd and 3rd hits ignored. A 4th hit after the window → `lives`=0, status=4.
5. Hit, then pause after 1 immune cycle; hold PAUSED 10 cycles with `scroll_got` pulses → `scrolls_left` unchanged. After unpause, `invulnerable` lasts 2 more cycles.
6. With `scrolls_left`=1 and `lives`=1, `scroll_got` and `hit` in the same cycle → status=1, `lives`=1. Separately, `rst` low during a banner → status=5 immediately.
